// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA scan generator: DrawX/DrawY counters, sync/blank decode and a
// PIPE_DLY-deep alignment pipeline. Define VGA_FRAME_COUNTER_EN to build the frame counter.
module vga_timing_gen #(
   parameter int   H_VISIBLE = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic HS_POL    = 1'b0,
   parameter logic VS_POL    = 1'b0,
   parameter int   PIPE_DLY  = 1
) (
   input  logic        pixel_clk,
   input  logic        Reset,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic hLast;
   logic vLast;
   logic hsRaw;
   logic vsRaw;
   logic blankRaw;

   assign hLast = (DrawX == H_LAST);
   assign vLast = (DrawY == V_LAST);

   // Pulses are registered from the wrap condition so they line up with the
   // counter value 0 they announce; nothing fires while leaving reset.
   always_ff @(posedge pixel_clk or posedge Reset) begin
      if (Reset) begin
         DrawX       <= '0;
         DrawY       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= hLast;
         frame_start <= hLast && vLast;
         if (hLast) begin
            DrawX <= '0;
            DrawY <= vLast ? 10'd0 : DrawY + 10'd1;
         end else begin
            DrawX <= DrawX + 10'd1;
         end
      end
   end

   assign hsRaw    = ((DrawX >= HS_START) && (DrawX < HS_END)) ? HS_POL : ~HS_POL;
   assign vsRaw    = ((DrawY >= VS_START) && (DrawY < VS_END)) ? VS_POL : ~VS_POL;
   assign blankRaw = (DrawX < H_VIS_END) && (DrawY < V_VIS_END);

   generate
      if (PIPE_DLY == 0) begin : gNoPipe
         // Pure decode: vs may glitch here and must not be used as a clock.
         assign hs    = hsRaw;
         assign vs    = vsRaw;
         assign blank = blankRaw;
      end else begin : gPipe
         logic [PIPE_DLY-1:0] hsQ;
         logic [PIPE_DLY-1:0] vsQ;
         logic [PIPE_DLY-1:0] blankQ;

         always_ff @(posedge pixel_clk or posedge Reset) begin
            if (Reset) begin
               hsQ    <= {PIPE_DLY{~HS_POL}};
               vsQ    <= {PIPE_DLY{~VS_POL}};
               blankQ <= '0;
            end else begin
               hsQ[0]    <= hsRaw;
               vsQ[0]    <= vsRaw;
               blankQ[0] <= blankRaw;
               for (int i = 1; i < PIPE_DLY; i++) begin
                  hsQ[i]    <= hsQ[i-1];
                  vsQ[i]    <= vsQ[i-1];
                  blankQ[i] <= blankQ[i-1];
               end
            end
         end

         // Last stage is a flop, so vs is glitch-free for the game logic.
         assign hs    = hsQ[PIPE_DLY-1];
         assign vs    = vsQ[PIPE_DLY-1];
         assign blank = blankQ[PIPE_DLY-1];
      end
   endgenerate

`ifdef VGA_FRAME_COUNTER_EN
   logic [15:0] frameCnt;

   // Advances on the same edge that raises frame_start, wrapping silently.
   always_ff @(posedge pixel_clk or posedge Reset) begin
      if (Reset) begin
         frameCnt <= '0;
      end else if (hLast && vLast) begin
         frameCnt <= frameCnt + 16'd1;
      end
   end

   assign frame_count = frameCnt;
`else
   assign frame_count = 16'd0;
`endif

endmodule
